// File: rtl/reg_file_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback path.
package rf_pkg;

   localparam int unsigned RF_ADDR_W = 5;
   localparam int unsigned RF_DATA_W = 32;
   localparam int unsigned RF_NREG   = 32;

   typedef struct packed {
      logic [RF_ADDR_W-1:0] addr;
      logic [RF_DATA_W-1:0] data;
   } wb_req_t;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_e;

endpackage

// File: rtl/reg_file_wb_arbiter_hold_buf.sv
// One-entry writeback holding buffer with valid/ready intake.
// A pop and a new load on the same edge leave the buffer full with the new entry.
module wb_hold_buf
   import rf_pkg::*;
#(
   parameter int unsigned ADDR_W = RF_ADDR_W,
   parameter int unsigned DATA_W = RF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop,
   output logic              o_load,
   output logic              o_full,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_data
);

   logic              r_full;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              w_load;

   // Ready is held low while in reset; otherwise free when empty or draining.
   assign o_ready = rst_n & (~r_full | i_pop);
   assign w_load  = i_valid & o_ready;
   assign o_load  = w_load;
   assign o_full  = r_full;
   assign o_addr  = r_addr;
   assign o_data  = r_data;

   // Entry storage: capture on transfer, empty on pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else if (w_load) begin
         r_full <= 1'b1;
         r_addr <= i_addr;
         r_data <= i_data;
      end else if (i_pop) begin
         r_full <= 1'b0;
      end
   end

endmodule

// File: rtl/reg_file_wb_arbiter.sv
// Two-requester writeback arbiter in front of the register-file write port.
// A = ALU result, B = memory load; entries drain oldest-first into a
// registered write stage, and busy_mask flags every pending destination.
module reg_file_wb_arbiter
   import rf_pkg::*;
#(
   parameter int unsigned DATA_W       = RF_DATA_W,
   parameter int unsigned ADDR_W       = RF_ADDR_W,
   parameter int unsigned NREG         = RF_NREG,
   parameter bit          ZERO_DISCARD = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              wr,
   output logic [ADDR_W-1:0] addr3,
   output logic [DATA_W-1:0] data3,
   output logic [NREG-1:0]   busy_mask
);

   logic              w_full_a, w_full_b;
   logic              w_load_a, w_load_b;
   logic [ADDR_W-1:0] w_addr_a, w_addr_b;
   logic [DATA_W-1:0] w_data_a, w_data_b;
   logic              w_drop_a, w_drop_b;
   logic              w_elig_a, w_elig_b;
   logic              w_grant_a, w_grant_b;
   logic              w_tied_grant;
   logic              w_pop_a, w_pop_b;

   logic              r_tie;
   req_id_e           r_old;
   req_id_e           r_rr;
   logic              r_wr;
   logic [ADDR_W-1:0] r_addr3;
   logic [DATA_W-1:0] r_data3;

   wb_hold_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_hold_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (a_valid),
      .o_ready (a_ready),
      .i_addr  (a_addr),
      .i_data  (a_data),
      .i_pop   (w_pop_a),
      .o_load  (w_load_a),
      .o_full  (w_full_a),
      .o_addr  (w_addr_a),
      .o_data  (w_data_a)
   );

   wb_hold_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_hold_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (b_valid),
      .o_ready (b_ready),
      .i_addr  (b_addr),
      .i_data  (b_data),
      .i_pop   (w_pop_b),
      .o_load  (w_load_b),
      .o_full  (w_full_b),
      .o_addr  (w_addr_b),
      .o_data  (w_data_b)
   );

   // Register-0 entries are dropped outside arbitration so they never
   // block or reorder the other requester.
   assign w_drop_a = ZERO_DISCARD && w_full_a && (w_addr_a == '0);
   assign w_drop_b = ZERO_DISCARD && w_full_b && (w_addr_b == '0);
   assign w_elig_a = w_full_a & ~w_drop_a;
   assign w_elig_b = w_full_b & ~w_drop_b;

   assign w_pop_a  = w_grant_a | w_drop_a;
   assign w_pop_b  = w_grant_b | w_drop_b;

   // Grant selection: single candidate wins; two candidates go by age, or rr on a tie.
   always_comb begin
      w_grant_a    = 1'b0;
      w_grant_b    = 1'b0;
      w_tied_grant = 1'b0;
      if (w_elig_a && w_elig_b) begin
         w_tied_grant = r_tie;
         if ((r_tie ? r_rr : r_old) == REQ_A) begin
            w_grant_a = 1'b1;
         end else begin
            w_grant_b = 1'b1;
         end
      end else begin
         w_grant_a = w_elig_a;
         w_grant_b = w_elig_b;
      end
   end

   // Age tracking: the most recently loaded buffer is the younger one, so
   // whenever both are full the other buffer is older; equal-edge loads mark a tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tie <= 1'b0;
         r_old <= REQ_A;
         r_rr  <= REQ_A;
      end else begin
         if (w_tied_grant) begin
            r_rr <= (r_rr == REQ_A) ? REQ_B : REQ_A;
         end
         if (w_load_a && w_load_b) begin
            r_tie <= 1'b1;
         end else if (w_load_a) begin
            r_tie <= 1'b0;
            r_old <= REQ_B;
         end else if (w_load_b) begin
            r_tie <= 1'b0;
            r_old <= REQ_A;
         end
      end
   end

   // Write stage: one-cycle write pulse; address and data hold when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr    <= 1'b0;
         r_addr3 <= '0;
         r_data3 <= '0;
      end else if (w_grant_a || w_grant_b) begin
         r_wr    <= 1'b1;
         r_addr3 <= w_grant_b ? w_addr_b : w_addr_a;
         r_data3 <= w_grant_b ? w_data_b : w_data_a;
      end else begin
         r_wr    <= 1'b0;
      end
   end

   assign wr    = r_wr;
   assign addr3 = r_addr3;
   assign data3 = r_data3;

   // Pending-write scoreboard over both held entries and the write stage.
   always_comb begin
      busy_mask = '0;
      if (w_elig_a) busy_mask[w_addr_a] = 1'b1;
      if (w_elig_b) busy_mask[w_addr_b] = 1'b1;
      if (r_wr)     busy_mask[r_addr3]  = 1'b1;
   end

endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// Self-checking bench for reg_file_wb_arbiter: cycle table for single/tie/
// same-address sequences, a write-order scoreboard, streaming, reset and
// register-0 discard scenarios.
module tb_reg_file_wb_arbiter;
   import rf_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        a_valid = 1'b0, b_valid = 1'b0;
   logic [4:0]  a_addr = '0, b_addr = '0;
   logic [31:0] a_data = '0, b_data = '0;
   logic        a_ready, b_ready, wr;
   logic [4:0]  addr3;
   logic [31:0] data3, busy_mask;

   logic        z_a_valid = 1'b0, z_b_valid = 1'b0;
   logic [4:0]  z_a_addr = '0, z_b_addr = '0;
   logic [31:0] z_a_data = '0, z_b_data = '0;
   logic        z_a_ready, z_b_ready, z_wr;
   logic [4:0]  z_addr3;
   logic [31:0] z_data3, z_busy;

   int n_checks = 0;
   int n_err    = 0;
   int wr_cnt   = 0;
   logic tb_rr  = 1'b0;
   wb_req_t sb[$];

   always #5 clk = ~clk;

   reg_file_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NREG(32), .ZERO_DISCARD(1'b0)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .wr(wr), .addr3(addr3), .data3(data3), .busy_mask(busy_mask)
   );

   reg_file_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NREG(32), .ZERO_DISCARD(1'b1)) dut_z (
      .clk(clk), .rst_n(rst_n),
      .a_valid(z_a_valid), .a_ready(z_a_ready), .a_addr(z_a_addr), .a_data(z_a_data),
      .b_valid(z_b_valid), .b_ready(z_b_ready), .b_addr(z_b_addr), .b_data(z_b_data),
      .wr(z_wr), .addr3(z_addr3), .data3(z_data3), .busy_mask(z_busy)
   );

   typedef struct {
      logic        av;
      logic [4:0]  aa;
      logic [31:0] ad;
      logic        bv;
      logic [4:0]  ba;
      logic [31:0] bd;
      logic        era;
      logic        erb;
      logic        ewr;
      logic [4:0]  ea3;
      logic [31:0] ed3;
      logic [31:0] ebusy;
   } vec_t;

   vec_t vecs[15];

   function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                               input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                               input logic era, input logic erb, input logic ewr,
                               input logic [4:0] ea3, input logic [31:0] ed3, input logic [31:0] ebusy);
      vec_t v;
      v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
      v.era = era; v.erb = erb; v.ewr = ewr; v.ea3 = ea3; v.ed3 = ed3; v.ebusy = ebusy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      a_valid = 1'b0; b_valid = 1'b0;
      z_a_valid = 1'b0; z_b_valid = 1'b0;
   endtask

   function automatic wb_req_t req(input logic [4:0] ad, input logic [31:0] d);
      wb_req_t r;
      r.addr = ad;
      r.data = d;
      return r;
   endfunction

   // Scoreboard: pops and compares each write, then records this cycle's handshakes.
   initial begin
      wb_req_t e;
      logic ha, hb;
      forever begin
         @(negedge clk);
         if (rst_n && wr) begin
            wr_cnt++;
            if (sb.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL sb_unexpected_wr: got write addr %0h data %0h, expected no write", addr3, data3);
            end else begin
               e = sb.pop_front();
               chk("sb_addr", {27'd0, addr3}, {27'd0, e.addr});
               chk("sb_data", data3, e.data);
            end
         end
         #2;
         if (rst_n) begin
            ha = a_valid & a_ready;
            hb = b_valid & b_ready;
            if (ha && hb) begin
               if (tb_rr == 1'b0) begin
                  sb.push_back(req(a_addr, a_data));
                  sb.push_back(req(b_addr, b_data));
               end else begin
                  sb.push_back(req(b_addr, b_data));
                  sb.push_back(req(a_addr, a_data));
               end
               tb_rr = ~tb_rr;
            end else if (ha) begin
               sb.push_back(req(a_addr, a_data));
            end else if (hb) begin
               sb.push_back(req(b_addr, b_data));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int ia, ib, cyc, wr0, t;

      // Row table: inputs for one cycle, readies before the edge, outputs after it.
      vecs[0]  = mk(1, 5, 32'h1234, 0, 0, 0,      1, 1, 0, 0, 32'h0,    32'h1 << 5);
      vecs[1]  = mk(0, 0, 0,        0, 0, 0,      1, 1, 1, 5, 32'h1234, 32'h1 << 5);
      vecs[2]  = mk(0, 0, 0,        0, 0, 0,      1, 1, 0, 5, 32'h1234, 32'h0);
      vecs[3]  = mk(1, 3, 32'hAA,   1, 7, 32'hBB, 1, 1, 0, 5, 32'h1234, (32'h1 << 3) | (32'h1 << 7));
      vecs[4]  = mk(0, 0, 0,        0, 0, 0,      1, 0, 1, 3, 32'hAA,   (32'h1 << 3) | (32'h1 << 7));
      vecs[5]  = mk(0, 0, 0,        0, 0, 0,      1, 1, 1, 7, 32'hBB,   32'h1 << 7);
      vecs[6]  = mk(0, 0, 0,        0, 0, 0,      1, 1, 0, 7, 32'hBB,   32'h0);
      vecs[7]  = mk(1, 3, 32'hAA,   1, 7, 32'hBB, 1, 1, 0, 7, 32'hBB,   (32'h1 << 3) | (32'h1 << 7));
      vecs[8]  = mk(0, 0, 0,        0, 0, 0,      0, 1, 1, 7, 32'hBB,   (32'h1 << 3) | (32'h1 << 7));
      vecs[9]  = mk(0, 0, 0,        0, 0, 0,      1, 1, 1, 3, 32'hAA,   32'h1 << 3);
      vecs[10] = mk(0, 0, 0,        0, 0, 0,      1, 1, 0, 3, 32'hAA,   32'h0);
      vecs[11] = mk(1, 9, 32'h1,    0, 0, 0,      1, 1, 0, 3, 32'hAA,   32'h1 << 9);
      vecs[12] = mk(0, 0, 0,        1, 9, 32'h2,  1, 1, 1, 9, 32'h1,    32'h1 << 9);
      vecs[13] = mk(0, 0, 0,        0, 0, 0,      1, 1, 1, 9, 32'h2,    32'h1 << 9);
      vecs[14] = mk(0, 0, 0,        0, 0, 0,      1, 1, 0, 9, 32'h2,    32'h0);

      // Reset state
      #1;
      chk("rst_wr", {31'd0, wr}, 32'd0);
      chk("rst_busy", busy_mask, 32'd0);
      chk("rst_ready", {30'd0, a_ready, b_ready}, 32'd0);
      chk("rst_addr3", {27'd0, addr3}, 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
         b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
         #1;
         chk($sformatf("row%0d_a_ready", i), {31'd0, a_ready}, {31'd0, vecs[i].era});
         chk($sformatf("row%0d_b_ready", i), {31'd0, b_ready}, {31'd0, vecs[i].erb});
         @(posedge clk); #1;
         idle();
         chk($sformatf("row%0d_wr", i), {31'd0, wr}, {31'd0, vecs[i].ewr});
         chk($sformatf("row%0d_addr3", i), {27'd0, addr3}, {27'd0, vecs[i].ea3});
         chk($sformatf("row%0d_data3", i), data3, vecs[i].ed3);
         chk($sformatf("row%0d_busy", i), busy_mask, vecs[i].ebusy);
      end

      // Streaming: both requesters valid until 20 entries each are accepted.
      ia = 0; ib = 0; cyc = 0; wr0 = wr_cnt;
      while ((ia < 20 || ib < 20) && cyc < 200) begin
         logic acc_a, acc_b;
         @(negedge clk);
         a_valid = (ia < 20); a_addr = 5'(ia + 1);  a_data = 32'h100 + ia;
         b_valid = (ib < 20); b_addr = 5'(ib + 10); b_data = 32'h200 + ib;
         #1;
         acc_a = a_valid & a_ready;
         acc_b = b_valid & b_ready;
         if (cyc >= 1 && cyc <= 36) chk("stream_ready_toggle", {31'd0, a_ready ^ b_ready}, 32'd1);
         @(posedge clk); #1;
         if (acc_a) ia++;
         if (acc_b) ib++;
         if (cyc >= 1) chk("stream_wr_every_cycle", {31'd0, wr}, 32'd1);
         cyc++;
      end
      idle();
      chk("stream_a_accepted", ia, 20);
      chk("stream_b_accepted", ib, 20);
      t = 0;
      while (sb.size() != 0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk); #3;
      chk("stream_sb_drained", sb.size(), 0);
      chk("stream_write_count", wr_cnt - wr0, 40);

      // Reset mid-operation with both buffers full and a write in flight.
      @(negedge clk);
      a_valid = 1'b1; a_addr = 5'd11; a_data = 32'h11;
      @(posedge clk); #1; idle();
      @(negedge clk);
      a_valid = 1'b1; a_addr = 5'd13; a_data = 32'h33;
      b_valid = 1'b1; b_addr = 5'd12; b_data = 32'h22;
      #1;
      chk("pre_rst_ready", {30'd0, a_ready, b_ready}, 32'd3);
      @(posedge clk); #1; idle();
      chk("pre_rst_wr", {31'd0, wr}, 32'd1);
      chk("pre_rst_busy", busy_mask, (32'h1 << 11) | (32'h1 << 12) | (32'h1 << 13));
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_wr", {31'd0, wr}, 32'd0);
      chk("mid_rst_busy", busy_mask, 32'd0);
      chk("mid_rst_ready", {30'd0, a_ready, b_ready}, 32'd0);
      chk("mid_rst_data3", data3, 32'd0);
      #1;
      sb.delete();
      tb_rr = 1'b0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("post_rst_ready", {30'd0, a_ready, b_ready}, 32'd3);
      @(negedge clk); #1;
      chk("post_rst_no_wr", {31'd0, wr}, 32'd0);
      chk("post_rst_busy", busy_mask, 32'd0);

      // Register-0 discard on the ZERO_DISCARD instance.
      @(negedge clk);
      z_b_valid = 1'b1; z_b_addr = 5'd0; z_b_data = 32'hFF;
      #1;
      chk("z0_ready_accept", {31'd0, z_b_ready}, 32'd1);
      @(posedge clk); #1; idle();
      chk("z0_ready_held", {31'd0, z_b_ready}, 32'd1);
      chk("z0_busy_held", z_busy, 32'd0);
      chk("z0_wr_held", {31'd0, z_wr}, 32'd0);
      @(posedge clk); #1;
      chk("z0_wr_after", {31'd0, z_wr}, 32'd0);
      chk("z0_busy_after", z_busy, 32'd0);
      @(negedge clk);
      z_b_valid = 1'b1; z_b_addr = 5'd4; z_b_data = 32'h44;
      @(posedge clk); #1; idle();
      chk("z4_busy", z_busy, 32'h1 << 4);
      @(posedge clk); #1;
      chk("z4_wr", {31'd0, z_wr}, 32'd1);
      chk("z4_addr3", {27'd0, z_addr3}, 32'd4);
      chk("z4_data3", z_data3, 32'h44);

      @(negedge clk); @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
